switch_debounce_ctrl: RTL

- Avalon-MM slave controller for the 3-bit board switch input.
- Synchronises and debounces each switch, captures edges and raises a maskable interrupt.
- Replaces the raw input PIO as the path from switches to the Nios II processor.
- Software reads clean levels and latched events instead of polling bouncing inputs.

---
 rtl/switch_debounce_ctrl_if.sv | 20 ++
 rtl/switch_debounce_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/switch_debounce_ctrl_if.sv
// Avalon-MM slave bus for the switch debounce controller.
// The master drives the strobes, address and write data; the slave returns registered read data.
interface switch_debounce_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/switch_debounce_ctrl.sv
// Switch input controller: 2-flop sync, per-bit debounce FSM, edge capture and maskable IRQ.
// Define SWITCH_DEBOUNCE_CTRL_BOTH_EDGES_EN to add per-bit EDGE_MODE at addr 1 bits [WIDTH+7:8].
module switch_debounce_ctrl #(
    parameter int unsigned WIDTH            = 3,
    parameter int unsigned CNT_W            = 20,
    parameter int unsigned DEBOUNCE_DEFAULT = 500000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    switch_debounce_ctrl_if.slave bus,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);
    typedef enum logic {StStable, StPending} bit_state_e;

    bit_state_e       state_q [WIDTH];
    bit_state_e       state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0] sync_q, raw_s_q, deb_q, deb_d, upd;
    logic [WIDTH-1:0] edge_q, edge_d, mask_q, mask_d, capt;
    logic [CNT_W-1:0] thr_q, thr_d, eff_thr;
    logic             irq_q, irq_d;
    logic [31:0]      rdata_q, rdata_d, rd_mux;
    logic             wr_en, rd_en, wr_mask, wr_edge, wr_thr;
    logic             unused_wdata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign wr_en        = bus.chipselect & bus.write;
    assign rd_en        = bus.chipselect & bus.read;
    assign wr_mask      = wr_en && (bus.address == 2'd1);
    assign wr_edge      = wr_en && (bus.address == 2'd2);
    assign wr_thr       = wr_en && (bus.address == 2'd3);
    assign eff_thr      = (thr_q == '0) ? CNT_W'(1) : thr_q;
    assign unused_wdata = ^bus.writedata;

`ifdef SWITCH_DEBOUNCE_CTRL_BOTH_EDGES_EN
    logic [WIDTH-1:0] mode_q, mode_d;

    assign mode_d = wr_mask ? bus.writedata[WIDTH+7:8] : mode_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= '0;
        end else begin
            mode_q <= mode_d;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            raw_s_q <= '0;
            deb_q   <= '0;
            edge_q  <= '0;
            mask_q  <= '0;
            thr_q   <= CNT_W'(DEBOUNCE_DEFAULT);
            irq_q   <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                state_q[i] <= StStable;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync_q  <= in_port;
            raw_s_q <= sync_q;
            deb_q   <= deb_d;
            edge_q  <= edge_d;
            mask_q  <= mask_d;
            thr_q   <= thr_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Per-bit debounce next-state
    always_comb begin
        upd = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (wr_thr) begin
                // A new threshold restarts any count in flight; settled levels are kept.
                state_d[i] = StStable;
                cnt_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    StStable: begin
                        if (raw_s_q[i] != deb_q[i]) begin
                            state_d[i] = StPending;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                    StPending: begin
                        if (raw_s_q[i] == deb_q[i]) begin
                            state_d[i] = StStable;
                            cnt_d[i]   = '0;
                        end else if (sat_inc(cnt_q[i]) >= eff_thr) begin
                            state_d[i] = StStable;
                            cnt_d[i]   = '0;
                            upd[i]     = 1'b1;
                        end else begin
                            cnt_d[i] = sat_inc(cnt_q[i]);
                        end
                    end
                endcase
            end
        end
    end

    // Outputs, edge capture and register file
    always_comb begin
        deb_d = (deb_q & ~upd) | (raw_s_q & upd);
        capt  = deb_d & ~deb_q;
`ifdef SWITCH_DEBOUNCE_CTRL_BOTH_EDGES_EN
        capt  = capt | (deb_q & ~deb_d & mode_q);
`endif
        edge_d = edge_q;
        if (wr_edge) begin
            edge_d = edge_q & ~bus.writedata[WIDTH-1:0];
        end
        // A capture in the same cycle as a clear wins.
        edge_d = edge_d | capt;
        mask_d = wr_mask ? bus.writedata[WIDTH-1:0] : mask_q;
        thr_d  = wr_thr ? bus.writedata[CNT_W-1:0] : thr_q;
        irq_d  = |(edge_q & mask_q);

        rd_mux = '0;
        unique case (bus.address)
            2'd0: rd_mux[WIDTH-1:0] = deb_q;
            2'd1: begin
                rd_mux[WIDTH-1:0] = mask_q;
`ifdef SWITCH_DEBOUNCE_CTRL_BOTH_EDGES_EN
                rd_mux[WIDTH+7:8] = mode_q;
`endif
            end
            2'd2: rd_mux[WIDTH-1:0] = edge_q;
            2'd3: rd_mux[CNT_W-1:0] = thr_q;
        endcase
        rdata_d = rd_en ? rd_mux : rdata_q;
    end

    assign bus.readdata = rdata_q;
    assign irq          = irq_q;

endmodule
